// File: rtl/vertex_sequencer.sv
// Vertex sequencer: walks a line-list vertex memory once per frame, pushes the
// camera pose and then each vertex through an external transform engine, culls
// segments with an off-screen endpoint and streams the rest to a line drawer.
module vertex_sequencer #(
   parameter int NUM_VERTS = 24,
   parameter int ADDR_W    = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              frame_start,
   input  logic [31:0]       cam_roll,
   input  logic [31:0]       cam_pitch,
   input  logic [31:0]       cam_yaw,
   input  logic [31:0]       cam_x,
   input  logic [31:0]       cam_y,
   input  logic [31:0]       cam_z,
   output logic [ADDR_W-1:0] vtx_addr,
   input  logic [95:0]       vtx_data,
   output logic              mvp_start,
   output logic              mvp_update_mvp,
   output logic [31:0]       mvp_roll,
   output logic [31:0]       mvp_pitch,
   output logic [31:0]       mvp_yaw,
   output logic [31:0]       mvp_x,
   output logic [31:0]       mvp_y,
   output logic [31:0]       mvp_z,
   input  logic              mvp_done,
   input  logic [31:0]       mvp_ox,
   input  logic [31:0]       mvp_oy,
   output logic              line_valid,
   input  logic              line_ready,
   output logic [9:0]        line_x0,
   output logic [8:0]        line_y0,
   output logic [9:0]        line_x1,
   output logic [8:0]        line_y1,
   output logic              busy,
   output logic              frame_done,
   output logic [15:0]       drop_count
);

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      UPD_START  = 4'd1,
      UPD_WAIT   = 4'd2,
      FETCH      = 4'd3,
      FETCH_WAIT = 4'd4,
      XF_START   = 4'd5,
      XF_WAIT    = 4'd6,
      STORE      = 4'd7,
      EMIT       = 4'd8,
      DONE       = 4'd9
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VERTS - 1);
   localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

   // The screen is 640x480; the engine output is a signed 32-bit integer, so a
   // negative coordinate (e.g. 32'hFFFFFFFF) must be rejected, not wrapped.
   function automatic logic on_screen(input logic [31:0] ox, input logic [31:0] oy);
      logic signed [31:0] sx;
      logic signed [31:0] sy;
      sx = ox;
      sy = oy;
      return (sx >= 32'sd0) && (sx <= 32'sd639) && (sy >= 32'sd0) && (sy <= 32'sd479);
   endfunction

   state_t            state_r;
   logic [ADDR_W-1:0] index_r;
   logic [31:0]       pose_roll_r;
   logic [31:0]       pose_pitch_r;
   logic [31:0]       pose_yaw_r;
   logic [31:0]       pose_x_r;
   logic [31:0]       pose_y_r;
   logic [31:0]       pose_z_r;
   logic [9:0]        ep0_x_r;
   logic [8:0]        ep0_y_r;
   logic              ep0_on_r;
   logic [9:0]        cur_x_r;
   logic [8:0]        cur_y_r;
   logic              cur_on_r;
   logic              last_vtx_s;

   // The memory address is the vertex index itself, already a register.
   assign vtx_addr   = index_r;
   assign last_vtx_s = (index_r == LAST_IDX);

   // Frame sequencing FSM; every output it drives is a register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r        <= IDLE;
         index_r        <= '0;
         pose_roll_r    <= 32'd0;
         pose_pitch_r   <= 32'd0;
         pose_yaw_r     <= 32'd0;
         pose_x_r       <= 32'd0;
         pose_y_r       <= 32'd0;
         pose_z_r       <= 32'd0;
         ep0_x_r        <= 10'd0;
         ep0_y_r        <= 9'd0;
         ep0_on_r       <= 1'b0;
         cur_x_r        <= 10'd0;
         cur_y_r        <= 9'd0;
         cur_on_r       <= 1'b0;
         mvp_start      <= 1'b0;
         mvp_update_mvp <= 1'b0;
         mvp_roll       <= 32'd0;
         mvp_pitch      <= 32'd0;
         mvp_yaw        <= 32'd0;
         mvp_x          <= 32'd0;
         mvp_y          <= 32'd0;
         mvp_z          <= 32'd0;
         line_valid     <= 1'b0;
         line_x0        <= 10'd0;
         line_y0        <= 9'd0;
         line_x1        <= 10'd0;
         line_y1        <= 9'd0;
         busy           <= 1'b0;
         frame_done     <= 1'b0;
         drop_count     <= 16'd0;
      end else begin
         case (state_r)
            IDLE: begin
               frame_done <= 1'b0;
               if (frame_start) begin
                  pose_roll_r  <= cam_roll;
                  pose_pitch_r <= cam_pitch;
                  pose_yaw_r   <= cam_yaw;
                  pose_x_r     <= cam_x;
                  pose_y_r     <= cam_y;
                  pose_z_r     <= cam_z;
                  index_r      <= '0;
                  drop_count   <= 16'd0;
                  busy         <= 1'b1;
                  state_r      <= UPD_START;
               end else begin
                  busy         <= 1'b0;
               end
            end

            UPD_START: begin
               if (mvp_done) begin
                  mvp_start      <= 1'b1;
                  mvp_update_mvp <= 1'b1;
                  mvp_roll       <= pose_roll_r;
                  mvp_pitch      <= pose_pitch_r;
                  mvp_yaw        <= pose_yaw_r;
                  mvp_x          <= pose_x_r;
                  mvp_y          <= pose_y_r;
                  mvp_z          <= pose_z_r;
                  state_r        <= UPD_WAIT;
               end else begin
                  state_r        <= UPD_START;
               end
            end

            // mvp_start is high only in the first wait cycle, when the engine
            // has not yet dropped mvp_done, so that cycle's done is ignored.
            UPD_WAIT: begin
               if (mvp_start) begin
                  mvp_start      <= 1'b0;
               end else if (mvp_done) begin
                  mvp_update_mvp <= 1'b0;
                  state_r        <= FETCH;
               end else begin
                  state_r        <= UPD_WAIT;
               end
            end

            FETCH: begin
               state_r <= FETCH_WAIT;
            end

            // Read data for the address shown in FETCH is valid now.
            FETCH_WAIT: begin
               mvp_x   <= vtx_data[95:64];
               mvp_y   <= vtx_data[63:32];
               mvp_z   <= vtx_data[31:0];
               state_r <= XF_START;
            end

            XF_START: begin
               if (mvp_done) begin
                  mvp_start      <= 1'b1;
                  mvp_update_mvp <= 1'b0;
                  state_r        <= XF_WAIT;
               end else begin
                  state_r        <= XF_START;
               end
            end

            // Same first-cycle blanking as UPD_WAIT; the result is captured in
            // the very cycle mvp_done comes back.
            XF_WAIT: begin
               if (mvp_start) begin
                  mvp_start <= 1'b0;
               end else if (mvp_done) begin
                  cur_x_r   <= mvp_ox[9:0];
                  cur_y_r   <= mvp_oy[8:0];
                  cur_on_r  <= on_screen(mvp_ox, mvp_oy);
                  state_r   <= STORE;
               end else begin
                  state_r   <= XF_WAIT;
               end
            end

            STORE: begin
               if (!index_r[0]) begin
                  ep0_x_r  <= cur_x_r;
                  ep0_y_r  <= cur_y_r;
                  ep0_on_r <= cur_on_r;
                  index_r  <= index_r + ONE_IDX;
                  state_r  <= FETCH;
               end else if (ep0_on_r && cur_on_r) begin
                  line_x0    <= ep0_x_r;
                  line_y0    <= ep0_y_r;
                  line_x1    <= cur_x_r;
                  line_y1    <= cur_y_r;
                  line_valid <= 1'b1;
                  state_r    <= EMIT;
               end else begin
                  if (drop_count != 16'hFFFF) begin
                     drop_count <= drop_count + 16'd1;
                  end else begin
                     drop_count <= drop_count;
                  end
                  if (last_vtx_s) begin
                     frame_done <= 1'b1;
                     state_r    <= DONE;
                  end else begin
                     index_r    <= index_r + ONE_IDX;
                     state_r    <= FETCH;
                  end
               end
            end

            // Payload registers are untouched here, so they hold while stalled.
            EMIT: begin
               if (line_ready) begin
                  line_valid <= 1'b0;
                  if (last_vtx_s) begin
                     frame_done <= 1'b1;
                     state_r    <= DONE;
                  end else begin
                     index_r    <= index_r + ONE_IDX;
                     state_r    <= FETCH;
                  end
               end else begin
                  state_r <= EMIT;
               end
            end

            DONE: begin
               frame_done <= 1'b0;
               busy       <= 1'b0;
               state_r    <= IDLE;
            end

            default: begin
               mvp_start  <= 1'b0;
               line_valid <= 1'b0;
               frame_done <= 1'b0;
               busy       <= 1'b0;
               state_r    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vertex_sequencer.sv
// Self-checking bench for vertex_sequencer: behavioural memory, transform
// engine and line sink, with a pair-wise culling model of each frame.
module tb_vertex_sequencer;

   localparam int NV = 6;
   localparam int AW = 3;

   logic          clock;
   logic          reset;
   logic          frame_start;
   logic [31:0]   cam_roll, cam_pitch, cam_yaw, cam_x, cam_y, cam_z;
   logic [AW-1:0] vtx_addr;
   logic [95:0]   vtx_data;
   logic          mvp_start, mvp_update_mvp;
   logic [31:0]   mvp_roll, mvp_pitch, mvp_yaw, mvp_x, mvp_y, mvp_z;
   logic          mvp_done;
   logic [31:0]   mvp_ox, mvp_oy;
   logic          line_valid, line_ready;
   logic [9:0]    line_x0, line_x1;
   logic [8:0]    line_y0, line_y1;
   logic          busy, frame_done;
   logic [15:0]   drop_count;

   vertex_sequencer #(.NUM_VERTS(NV), .ADDR_W(AW)) dut (
      .clock(clock), .reset(reset), .frame_start(frame_start),
      .cam_roll(cam_roll), .cam_pitch(cam_pitch), .cam_yaw(cam_yaw),
      .cam_x(cam_x), .cam_y(cam_y), .cam_z(cam_z),
      .vtx_addr(vtx_addr), .vtx_data(vtx_data),
      .mvp_start(mvp_start), .mvp_update_mvp(mvp_update_mvp),
      .mvp_roll(mvp_roll), .mvp_pitch(mvp_pitch), .mvp_yaw(mvp_yaw),
      .mvp_x(mvp_x), .mvp_y(mvp_y), .mvp_z(mvp_z),
      .mvp_done(mvp_done), .mvp_ox(mvp_ox), .mvp_oy(mvp_oy),
      .line_valid(line_valid), .line_ready(line_ready),
      .line_x0(line_x0), .line_y0(line_y0), .line_x1(line_x1), .line_y1(line_y1),
      .busy(busy), .frame_done(frame_done), .drop_count(drop_count)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0]  mem_x [NV];
   logic [31:0]  mem_y [NV];
   logic [31:0]  mem_z [NV];
   logic [191:0] exp_pose;
   logic [37:0]  exp_q [$];
   logic [37:0]  got_q [$];
   int           exp_drops;
   int           upd_cnt, xf_cnt, fd_cnt, run_min, run_max;
   bit           first_upd;
   int           ready_mode;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit visible(input logic [31:0] x, input logic [31:0] y);
      int sx;
      int sy;
      sx = x;
      sy = y;
      return (sx >= 0) && (sx < 640) && (sy >= 0) && (sy < 480);
   endfunction

   // Reference: vertices pair up (2p, 2p+1); a pair is drawn iff both are visible.
   task automatic build_expected();
      exp_q.delete();
      exp_drops = 0;
      for (int p = 0; p < NV; p += 2) begin
         if (visible(mem_x[p], mem_y[p]) && visible(mem_x[p+1], mem_y[p+1]))
            exp_q.push_back({mem_x[p][9:0], mem_y[p][8:0], mem_x[p+1][9:0], mem_y[p+1][8:0]});
         else
            exp_drops++;
      end
   endtask

   function automatic logic [31:0] pick(input int lim);
      logic [31:0] r;
      case ($urandom_range(0, 7))
         0: r = 32'hFFFF_FFFF;
         1: r = 32'(lim);
         2: r = 32'd0;
         3: r = 32'(lim - 1);
         4: r = 32'h8000_0000 | 32'($urandom);
         default: r = 32'($urandom_range(0, lim - 1));
      endcase
      return r;
   endfunction

   task automatic fill_random(input bit in_range);
      for (int i = 0; i < NV; i++) begin
         mem_x[i] = in_range ? 32'($urandom_range(0, 639)) : pick(640);
         mem_y[i] = in_range ? 32'($urandom_range(0, 479)) : pick(480);
         mem_z[i] = $urandom;
      end
   endtask

   // Vertex memory: one-cycle read latency.
   initial begin
      logic [AW-1:0] a;
      vtx_data = 96'd0;
      forever begin
         @(negedge clock);
         a = vtx_addr;
         @(posedge clock);
         #1;
         vtx_data = (int'(a) < NV) ? {mem_x[a], mem_y[a], mem_z[a]} : 96'd0;
      end
   end

   // Transform engine: identity projection (ox=x, oy=y), latency 1..4 cycles.
   initial begin
      logic [192:0] ops;
      logic [31:0]  res_x, res_y;
      int           lat;
      bit           aborted;
      mvp_done = 1'b1;
      mvp_ox   = 32'd0;
      mvp_oy   = 32'd0;
      forever begin
         @(negedge clock);
         if (mvp_start && !reset) begin
            chk("start_while_idle", mvp_done, 1'b1);
            ops = {mvp_roll, mvp_pitch, mvp_yaw, mvp_x, mvp_y, mvp_z, mvp_update_mvp};
            if (upd_cnt + xf_cnt == 0) first_upd = mvp_update_mvp;
            if (mvp_update_mvp) begin
               upd_cnt++;
               chk("update_pose", {mvp_roll, mvp_pitch, mvp_yaw, mvp_x, mvp_y, mvp_z}, exp_pose);
               res_x = $urandom;
               res_y = $urandom;
            end else begin
               if (xf_cnt < NV)
                  chk("xf_operands", {mvp_roll, mvp_pitch, mvp_yaw, mvp_x, mvp_y, mvp_z},
                      {exp_pose[191:96], mem_x[xf_cnt], mem_y[xf_cnt], mem_z[xf_cnt]});
               xf_cnt++;
               res_x = mvp_x;
               res_y = mvp_y;
            end
            aborted = 1'b0;
            @(posedge clock);
            #1 mvp_done = 1'b0;
            lat = $urandom_range(1, 4);
            for (int c = 0; c < lat; c++) begin
               @(negedge clock);
               if (reset) aborted = 1'b1;
               if (!aborted)
                  chk("operands_stable",
                      {mvp_roll, mvp_pitch, mvp_yaw, mvp_x, mvp_y, mvp_z, mvp_update_mvp}, ops);
               @(posedge clock);
            end
            #1;
            mvp_done = 1'b1;
            mvp_ox   = res_x;
            mvp_oy   = res_y;
         end
      end
   end

   // Line sink: always ready, 5-cycle stall per segment, or random.
   initial begin
      int vcnt;
      vcnt = 0;
      line_ready = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         case (ready_mode)
            0: line_ready = 1'b1;
            1: begin
               if (line_valid) begin
                  line_ready = (vcnt >= 5);
                  vcnt++;
               end else begin
                  vcnt = 0;
                  line_ready = 1'b0;
               end
            end
            default: line_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Stream monitor: handshake rules, payload stability, segment capture.
   initial begin
      logic [37:0]   pay, prev_pay;
      logic [AW-1:0] prev_addr;
      bit            prev_valid, prev_fire;
      int            run;
      prev_valid = 1'b0;
      prev_fire  = 1'b0;
      prev_pay   = '0;
      prev_addr  = '0;
      run        = 0;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev_valid = 1'b0;
            prev_fire  = 1'b0;
            run        = 0;
         end else begin
            pay = {line_x0, line_y0, line_x1, line_y1};
            chk("start_and_valid_exclusive", mvp_start & line_valid, 1'b0);
            if (frame_done) begin
               fd_cnt++;
               chk("busy_during_done", busy, 1'b1);
            end
            if (prev_fire) chk("valid_low_after_transfer", line_valid, 1'b0);
            if (line_valid) begin
               run++;
               if (prev_valid && !prev_fire) begin
                  chk("payload_stable", pay, prev_pay);
                  chk("no_fetch_while_stalled", vtx_addr, prev_addr);
               end
               if (line_ready) begin
                  got_q.push_back(pay);
                  if (run < run_min) run_min = run;
                  if (run > run_max) run_max = run;
                  run = 0;
               end
            end else begin
               run = 0;
            end
            prev_valid = line_valid;
            prev_fire  = line_valid && line_ready;
            prev_pay   = pay;
            prev_addr  = vtx_addr;
         end
      end
   end

   task automatic set_cam_random();
      cam_roll  = $urandom;
      cam_pitch = $urandom;
      cam_yaw   = $urandom;
      cam_x     = $urandom;
      cam_y     = $urandom;
      cam_z     = $urandom;
   endtask

   task automatic begin_frame(input int mode);
      ready_mode = mode;
      build_expected();
      got_q.delete();
      upd_cnt = 0;
      xf_cnt  = 0;
      fd_cnt  = 0;
      run_min = 1000;
      run_max = 0;
      set_cam_random();
      exp_pose = {cam_roll, cam_pitch, cam_yaw, cam_x, cam_y, cam_z};
      @(posedge clock);
      #2 frame_start = 1'b1;
      @(posedge clock);
      #2 frame_start = 1'b0;
      set_cam_random();
      @(negedge clock);
      chk("busy_after_start", busy, 1'b1);
   endtask

   task automatic run_frame(input int mode, input bit inject);
      bit injected;
      begin_frame(mode);
      injected = 1'b0;
      for (int cyc = 0; cyc < 3000 && fd_cnt == 0; cyc++) begin
         @(posedge clock);
         #2;
         frame_start = 1'b0;
         if (inject && !injected && xf_cnt >= 2 && !mvp_done) begin
            frame_start = 1'b1;
            injected    = 1'b1;
         end
      end
      chk("frame_done_within_budget", fd_cnt != 0, 1'b1);
      frame_start = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      chk("frame_done_pulses", fd_cnt, 1);
      chk("busy_after_frame", busy, 1'b0);
      chk("drop_count", drop_count, exp_drops);
      chk("update_starts", upd_cnt, 1);
      chk("transform_starts", xf_cnt, NV);
      chk("first_start_is_update", first_upd, 1'b1);
      chk("segment_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk("segment_payload", got_q[i], exp_q[i]);
      if (mode == 1 && exp_q.size() > 0) begin
         chk("stall_valid_cycles_min", run_min, 6);
         chk("stall_valid_cycles_max", run_max, 6);
      end
   endtask

   task automatic check_reset_values();
      chk("rst_busy", busy, 1'b0);
      chk("rst_mvp_start", mvp_start, 1'b0);
      chk("rst_mvp_update", mvp_update_mvp, 1'b0);
      chk("rst_line_valid", line_valid, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_drop_count", drop_count, 16'd0);
      chk("rst_vtx_addr", vtx_addr, 3'd0);
      chk("rst_line_payload", {line_x0, line_y0, line_x1, line_y1}, 38'd0);
   endtask

   initial begin
      reset       = 1'b1;
      frame_start = 1'b0;
      ready_mode  = 0;
      first_upd   = 1'b0;
      upd_cnt     = 0;
      xf_cnt      = 0;
      fd_cnt      = 0;
      exp_pose    = '0;
      set_cam_random();
      fill_random(1'b1);
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_reset_values();
      @(posedge clock);
      #2 reset = 1'b0;

      // Basic segment (100,50)-(200,60), all others visible.
      fill_random(1'b1);
      mem_x[0] = 32'd100; mem_y[0] = 32'd50;
      mem_x[1] = 32'd200; mem_y[1] = 32'd60;
      run_frame(0, 1'b0);

      // Culling: ox=640 on vertex 1, oy=-1 on vertex 2, exact edges kept.
      fill_random(1'b1);
      mem_x[1] = 32'd640;
      mem_y[2] = 32'hFFFF_FFFF;
      mem_x[4] = 32'd639; mem_y[4] = 32'd479;
      mem_x[5] = 32'd0;   mem_y[5] = 32'd0;
      run_frame(0, 1'b0);

      // Back-pressure: every segment stalled 5 cycles.
      fill_random(1'b1);
      run_frame(1, 1'b0);

      // frame_start during XF_WAIT must be ignored.
      fill_random(1'b0);
      run_frame(2, 1'b1);

      // Random frames with boundary-heavy coordinates.
      for (int f = 0; f < 4; f++) begin
         fill_random(1'b0);
         run_frame(2, 1'b0);
      end

      // Reset in XF_WAIT together with frame_start, then a clean frame.
      fill_random(1'b0);
      begin_frame(2);
      for (int cyc = 0; cyc < 500 && !(xf_cnt >= 2 && !mvp_done); cyc++) @(posedge clock);
      chk("reached_xf_wait", xf_cnt >= 2 && !mvp_done, 1'b1);
      #2;
      reset       = 1'b1;
      frame_start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check_reset_values();
      @(posedge clock);
      #2;
      reset       = 1'b0;
      frame_start = 1'b0;
      @(negedge clock);
      chk("idle_after_reset_release", busy, 1'b0);
      fill_random(1'b0);
      run_frame(0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vertex_sequencer.md
VERTEX_SEQUENCER -- requirements
Module: vertex_sequencer

Interface
REQ-001 SHALL have parameter NUM_VERTS, default 24, meaning vertices per frame as a line list; SHALL be even and >= 2.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning vertex memory address width; SHALL satisfy 2^ADDR_W >= NUM_VERTS.
REQ-003 SHALL have port clock  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high.
REQ-005 SHALL have port frame_start  in  1  single-cycle request to process one frame.
REQ-006 SHALL have ports cam_roll/cam_pitch/cam_yaw/cam_x/cam_y/cam_z  in  32 each  IEEE-754 single camera pose.
REQ-007 SHALL have port vtx_addr  out  ADDR_W  vertex memory address; read data valid 1 cycle after the address is presented.
REQ-008 SHALL have port vtx_data  in  96  {x[95:64], y[63:32], z[31:0]} IEEE-754 single.
REQ-009 SHALL have ports mvp_start, mvp_update_mvp  out  1  request and mode to the transform engine.
REQ-010 SHALL have ports mvp_roll/mvp_pitch/mvp_yaw/mvp_x/mvp_y/mvp_z  out  32 each  engine operands.
REQ-011 SHALL have port mvp_done  in  1  engine idle; it is high only while the engine is idle and drops the cycle after an accepted start.
REQ-012 SHALL have ports mvp_ox, mvp_oy  in  32 each  signed integer screen coordinates, valid while mvp_done is high after a transform.
REQ-013 SHALL have ports line_valid  out  1, line_ready  in  1, line_x0/line_x1  out  10, line_y0/line_y1  out  9  for the segment stream to the line drawer.
REQ-014 SHALL have ports busy  out  1, frame_done  out  1 (one-cycle pulse), drop_count  out  16 (segments culled in the current frame).

Function
REQ-015 SHALL implement states IDLE, UPD_START, UPD_WAIT, FETCH, FETCH_WAIT, XF_START, XF_WAIT, STORE, EMIT, DONE.
REQ-016 In IDLE with frame_start=1, SHALL latch all six camera inputs, clear the vertex index and drop_count, and go to UPD_START; frame_start outside IDLE SHALL be ignored.
REQ-017 UPD_START SHALL wait for mvp_done=1, then assert mvp_start for exactly 1 cycle with mvp_update_mvp=1, driving the latched pose on mvp_roll..mvp_z, and go to UPD_WAIT.
REQ-018 UPD_WAIT SHALL ignore mvp_done in its first cycle, then go to FETCH on the first cycle with mvp_done=1.
REQ-019 FETCH SHALL drive vtx_addr = vertex index; FETCH_WAIT SHALL capture vtx_data into the operand registers on the following cycle.
REQ-020 XF_START SHALL assert mvp_start for 1 cycle with mvp_update_mvp=0; XF_WAIT SHALL apply the same one-cycle blanking rule as REQ-018.
REQ-021 mvp_x/y/z and mvp_roll/pitch/yaw SHALL remain stable from the start cycle until mvp_done returns high.
REQ-022 STORE SHALL sample mvp_ox/mvp_oy in the cycle mvp_done returns high, and mark the vertex on-screen iff 0<=ox<=639 and 0<=oy<=479 (signed compare).
REQ-023 After an even-index vertex, STORE SHALL store it as endpoint 0, increment the index, and go to FETCH.
REQ-024 After an odd-index vertex, STORE SHALL go to EMIT if both endpoints are on-screen; otherwise it SHALL increment drop_count (saturating at 16'hFFFF) and skip EMIT.
REQ-025 EMIT SHALL hold line_valid=1 with endpoint 0 on x0/y0 and endpoint 1 on x1/y1 (low 10/9 bits) until line_ready=1; payload SHALL be stable while valid and not ready.
REQ-026 Transfer SHALL occur on the cycle where line_valid=1 and line_ready=1; line_valid SHALL be low the next cycle.
REQ-027 After the last vertex (index NUM_VERTS-1) has been emitted or dropped, SHALL go to DONE; otherwise SHALL increment the index and go to FETCH.
REQ-028 DONE SHALL pulse frame_done for 1 cycle and return to IDLE; drop_count SHALL hold until the next accepted frame_start.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 mvp_start and line_valid SHALL never be high simultaneously.

Reset
REQ-031 On reset: state IDLE; mvp_start, mvp_update_mvp, line_valid, frame_done, busy = 0; drop_count, vtx_addr, vertex index, line_* = 0.
REQ-032 Reset SHALL override any in-progress frame, including an in-flight engine request, and SHALL take priority over a simultaneous frame_start.

Verification
REQ-033 NUM_VERTS=2, both vertices map to (100,50)/(200,60), line_ready=1 -> one update start, two transform starts, one segment x0=100,y0=50,x1=200,y1=60, frame_done pulse, drop_count=0.
REQ-034 Vertex 1 maps to ox=640 -> no line_valid, drop_count=1, frame_done still pulses.
REQ-035 Vertex 0 maps to oy=-1 (32'hFFFFFFFF) -> segment dropped (signed compare), drop_count=1.
REQ-036 line_ready held low 5 cycles during EMIT -> line_valid high and payload constant for 6 cycles, single transfer, no further fetch until accepted.
REQ-037 frame_start pulsed during XF_WAIT -> ignored, exactly NUM_VERTS transforms per frame; mvp_x/y/z constant start-to-done.
REQ-038 Reset asserted in XF_WAIT, then frame_start -> outputs at reset values, new frame restarts at vtx_addr=0 with an update request first.
